// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundle of the two requester ports and the single-port RAM
//               bus served by ram_arbiter.
//   slave  : arbiter view. It samples requests and ram_dout, and drives
//            grants, read valids, rdata, init_done and the ram_* command.
//   master : environment view. It holds the requesters and the RAM.
// Ports       : req0/1, we0/1, addr0/1, wdata0/1   requester commands
//               gnt0/1, rvalid0/1, rdata            requester responses
//               init_done                           clear sequence finished
//               ram_rst, ram_wen, ram_addr, ram_din RAM command
//               ram_dout                            RAM read data
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              init_done;
    logic              ram_rst;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, init_done,
               ram_rst, ram_wen, ram_addr, ram_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, init_done,
               ram_rst, ram_wen, ram_addr, ram_din
    );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-requester round-robin arbiter for a single-port RAM with
//               synchronous read. After reset it writes CLEAR_VAL to every
//               location (CLEAR state) and then serves requests (ARB state).
// Ports       : clk    - rising-edge clock
//               reset  - asynchronous, active-low reset
//               bus    - ram_arbiter_if.slave (requesters and RAM bus)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    ram_arbiter_if.slave      bus
);

    localparam logic [0:0]        c_ST_CLEAR = 1'b0;
    localparam logic [0:0]        c_ST_ARB   = 1'b1;
    localparam logic [ADDR_W-1:0] c_CNT_LAST = {ADDR_W{1'b1}};

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_init_done;
    logic              r_ptr;       // 0: requester 0 has priority
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_ram_wen;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;

    logic w_elig0;
    logic w_elig1;
    logic w_win0;
    logic w_win1;

    // A requester granted this cycle is still holding its request, so it is
    // masked to avoid granting it twice. Eligibility also waits for
    // init_done, which delays the first grant to the cycle after it rises.
    assign w_elig0 = bus.req0 & ~r_gnt0 & r_init_done;
    assign w_elig1 = bus.req1 & ~r_gnt1 & r_init_done;
    assign w_win0  = w_elig0 & (~w_elig1 | ~r_ptr);
    assign w_win1  = w_elig1 & (~w_elig0 |  r_ptr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_CLEAR;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_ptr       <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
        end else begin
            // ram_wen still carries the we of the grant issued this cycle,
            // so a read grant produces rvalid exactly one cycle later, when
            // the RAM has registered the read data.
            r_rvalid0 <= r_gnt0 & ~r_ram_wen;
            r_rvalid1 <= r_gnt1 & ~r_ram_wen;

            case (r_state)
                c_ST_CLEAR: begin
                    r_gnt0     <= 1'b0;
                    r_gnt1     <= 1'b0;
                    r_ram_wen  <= 1'b1;
                    r_ram_addr <= r_cnt;
                    r_ram_din  <= CLEAR_VAL;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_ARB;
                    end
                end
                default: begin
                    r_init_done <= 1'b1;
                    r_gnt0      <= w_win0;
                    r_gnt1      <= w_win1;
                    if (w_win0) begin
                        r_ram_wen  <= bus.we0;
                        r_ram_addr <= bus.addr0;
                        r_ram_din  <= bus.wdata0;
                        r_ptr      <= 1'b1;
                    end else if (w_win1) begin
                        r_ram_wen  <= bus.we1;
                        r_ram_addr <= bus.addr1;
                        r_ram_din  <= bus.wdata1;
                        r_ptr      <= 1'b0;
                    end else begin
                        // Address and data hold so the RAM bus stays quiet.
                        r_ram_wen <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;
    assign bus.rdata     = bus.ram_dout;
    assign bus.init_done = r_init_done;
    assign bus.ram_rst   = ~reset;
    assign bus.ram_wen   = r_ram_wen;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_din   = r_ram_din;

endmodule
`default_nettype wire
